// File: rtl/fp_div_seq.sv
// Sequential fixed-point divider, c = a / b, one quotient bit per clock.
// Restoring division of |a| (pre-scaled to the quotient's fraction) by |b|;
// the sign is applied and the result saturated in a final fix-up cycle.
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (ready only while idle)
//   a, s1                 dividend, s1=1 means two's complement
//   b, s2                 divisor,  s2=1 means two's complement
//   out_valid/out_ready   result handshake, result held until accepted
//   c, sign               quotient; sign=1 means c is two's complement
//   overflow              c saturated (also set on divide by zero)
//   underflow             nonzero remainder, c truncated toward zero
//   div_by_zero           b was zero
module fp_div_seq #(
  parameter int i1 = 2,
  parameter int f1 = 14,
  parameter int i2 = 2,
  parameter int f2 = 14,
  parameter int i3 = 2,
  parameter int f3 = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [i1+f1-1:0] a,
  input  logic             s1,
  input  logic [i2+f2-1:0] b,
  input  logic             s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [i3+f3-1:0] c,
  output logic             sign,
  output logic             overflow,
  output logic             underflow,
  output logic             div_by_zero
);

  localparam int W1 = i1 + f1;
  localparam int W2 = i2 + f2;
  localparam int W3 = i3 + f3;
  localparam int SH = f2 + f3 - f1;
  localparam int NW = W1 + SH;
  localparam int CW = $clog2(NW + 1);

  localparam logic [W3-1:0] NegMin  = {1'b1, {(W3-1){1'b0}}};
  localparam logic [W3-1:0] SPosMax = {1'b0, {(W3-1){1'b1}}};
  localparam logic [W3-1:0] UPosMax = {W3{1'b1}};
  localparam logic [NW-1:0] SMaxMag = NW'(SPosMax);
  localparam logic [NW-1:0] UMaxMag = NW'(UPosMax);
  localparam logic [NW-1:0] NMaxMag = NW'(NegMin);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Dividend shifts out at the top while quotient bits shift in at the bottom.
  logic [NW-1:0] nq_q, nq_d;
  logic [W2-1:0] rem_q, rem_d;
  logic [W2-1:0] bmag_q, bmag_d;
  logic          neg_q, neg_d;
  logic          sgn_q, sgn_d;
  logic          dz_q, dz_d;
  logic          aneg_q, aneg_d;
  logic [W3-1:0] c_q, c_d;
  logic          sign_q, sign_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          dzo_q, dzo_d;

  logic          a_neg, b_neg;
  logic [W1-1:0] a_mag;
  logic [W2-1:0] b_mag;
  logic [W2:0]   trial;
  logic [W2-1:0] diff;
  logic          ge;
  logic [W3-1:0] q_lo;
  logic [W3-1:0] pos_max;

  assign a_neg = s1 & a[W1-1];
  assign b_neg = s2 & b[W2-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  assign trial = {rem_q, nq_q[NW-1]};
  assign ge    = trial >= {1'b0, bmag_q};
  // When ge holds the difference is below bmag, so W2 bits are enough.
  assign diff  = trial[W2-1:0] - bmag_q;

  assign q_lo    = nq_q[W3-1:0];
  assign pos_max = sgn_q ? SPosMax : UPosMax;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nq_d    = nq_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    dz_d    = dz_q;
    aneg_d  = aneg_q;
    c_d     = c_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dzo_d   = dzo_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          nq_d   = NW'(a_mag) << SH;
          rem_d  = '0;
          bmag_d = b_mag;
          neg_d  = a_neg ^ b_neg;
          sgn_d  = s1 | s2;
          aneg_d = a_neg;
          dz_d   = (b == '0);
          // A zero divisor makes a single dummy pass so its result lands two
          // cycles after accept; the iterated bits are discarded in fix-up.
          cnt_d   = (b == '0) ? CW'(1) : CW'(NW);
          state_d = StCalc;
        end
      end
      StCalc: begin
        rem_d = ge ? diff : trial[W2-1:0];
        nq_d  = {nq_q[NW-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = StFix;
      end
      StFix: begin
        sign_d = sgn_q;
        dzo_d  = dz_q;
        ovf_d  = 1'b0;
        unf_d  = (rem_q != '0);
        if (dz_q) begin
          c_d   = aneg_q ? NegMin : pos_max;
          ovf_d = 1'b1;
          unf_d = 1'b0;
        end else if (neg_q) begin
          if (nq_q > NMaxMag) begin
            c_d   = NegMin;
            ovf_d = 1'b1;
          end else begin
            c_d = ~q_lo + 1'b1;
          end
        end else if (nq_q > (sgn_q ? SMaxMag : UMaxMag)) begin
          c_d   = pos_max;
          ovf_d = 1'b1;
        end else begin
          c_d = q_lo;
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      nq_q    <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
      aneg_q  <= 1'b0;
      c_q     <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nq_q    <= nq_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
      aneg_q  <= aneg_d;
      c_q     <= c_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dzo_q   <= dzo_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign c           = c_q;
  assign sign        = sign_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq with default Q2.14 operands/result.
// Expected results come from an integer arithmetic model pushed to a
// scoreboard queue at accept time and popped when out_valid rises.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic        s1;
  logic [15:0] b;
  logic        s2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c;
  logic        sign;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [15:0] c;
    logic        sign;
    logic        ovf;
    logic        unf;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .s1          (s1),
    .b           (b),
    .s2          (s2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .c           (c),
    .sign        (sign),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value-level model: interpret operands, divide with truncation toward
  // zero, then clamp to the result format.
  function automatic exp_t model(input logic [15:0] av, input logic sa,
                                 input logic [15:0] bv, input logic sb);
    exp_t   e;
    longint x, y, n, q, r;
    x = sa ? longint'($signed(av)) : longint'(av);
    y = sb ? longint'($signed(bv)) : longint'(bv);
    e.sign = sa | sb;
    e.ovf  = 1'b0;
    e.unf  = 1'b0;
    e.dz   = 1'b0;
    e.lat  = 31;
    if (y == 0) begin
      e.dz  = 1'b1;
      e.ovf = 1'b1;
      e.lat = 2;
      e.c   = (x < 0) ? 16'h8000 : (e.sign ? 16'h7FFF : 16'hFFFF);
    end else begin
      n     = x * 16384;
      q     = n / y;
      r     = n % y;
      e.unf = (r != 0);
      if (e.sign) begin
        if (q > 32767) begin
          e.c = 16'h7FFF; e.ovf = 1'b1;
        end else if (q < -32768) begin
          e.c = 16'h8000; e.ovf = 1'b1;
        end else begin
          e.c = q[15:0];
        end
      end else if (q > 65535) begin
        e.c = 16'hFFFF; e.ovf = 1'b1;
      end else begin
        e.c = q[15:0];
      end
    end
    return e;
  endfunction

  task automatic run_op(input string name, input logic [15:0] av, input logic sa,
                        input logic [15:0] bv, input logic sb, input int hold,
                        input bit poke);
    exp_t        e;
    int          lat;
    int          guard;
    logic [15:0] c0;
    logic [3:0]  f0;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check({name, ".ready"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    a = av; s1 = sa; b = bv; s2 = sb; in_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back(model(av, sa, bv, sb));
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      // Operands offered while busy must be ignored.
      if (poke && lat == 3) begin
        a = ~av; b = 16'h1234; s1 = ~sa; in_valid = 1'b1;
      end
      if (poke && lat == 6) in_valid = 1'b0;
    end
    check({name, ".out_valid"}, 32'(out_valid), 32'd1);
    e = sb_q.pop_front();
    check({name, ".latency"}, 32'(lat), 32'(e.lat));
    check({name, ".c"}, 32'(c), 32'(e.c));
    check({name, ".sign"}, 32'(sign), 32'(e.sign));
    check({name, ".overflow"}, 32'(overflow), 32'(e.ovf));
    check({name, ".underflow"}, 32'(underflow), 32'(e.unf));
    check({name, ".div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
    c0 = c;
    f0 = {sign, overflow, underflow, div_by_zero};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, ".hold"}, 32'({out_valid, in_ready, c, sign, overflow, underflow,
                                  div_by_zero}), 32'({1'b1, 1'b0, c0, f0}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, ".release"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; s1 = 1'b0; s2 = 1'b0;
    #3;
    check("reset_state", 32'({in_ready, out_valid, c, sign, overflow, underflow, div_by_zero}),
          32'({1'b1, 1'b0, 16'h0, 4'h0}));
    @(posedge clk); #1 rst_n = 1'b1;

    run_op("u_2p0",      16'h4000, 1'b0, 16'h2000, 1'b0, 0, 1'b0);
    run_op("s_m2p0",     16'hC000, 1'b1, 16'h2000, 1'b1, 0, 1'b0);
    run_op("u_sat",      16'hC000, 1'b0, 16'h2000, 1'b0, 0, 1'b0);
    run_op("s_possat",   16'h4000, 1'b1, 16'h1000, 1'b0, 0, 1'b0);
    run_op("u_third",    16'h4000, 1'b0, 16'hC000, 1'b0, 0, 1'b1);
    run_op("dz_pos",     16'h4000, 1'b1, 16'h0000, 1'b0, 0, 1'b0);
    run_op("dz_neg",     16'hC000, 1'b1, 16'h0000, 1'b1, 0, 1'b0);
    run_op("dz_uns",     16'h4000, 1'b0, 16'h0000, 1'b0, 0, 1'b0);
    run_op("s_negneg",   16'hC000, 1'b1, 16'hE000, 1'b1, 0, 1'b0);
    run_op("s_half",     16'hC000, 1'b1, 16'h8000, 1'b1, 0, 1'b0);
    run_op("s_neginex",  16'h4000, 1'b0, 16'hD000, 1'b1, 0, 1'b0);
    run_op("hold10",     16'h3000, 1'b0, 16'h5000, 1'b0, 10, 1'b0);

    // Reset pulse in the middle of an operation discards it.
    a = 16'h4000; s1 = 1'b0; b = 16'h2000; s2 = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async", 32'({in_ready, out_valid, c, sign, overflow, underflow, div_by_zero}),
          32'({1'b1, 1'b0, 16'h0, 4'h0}));
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_out_valid", 32'(seen), 32'd0);
    check("rst_idle_ready", 32'(in_ready), 32'd1);

    run_op("post_rst", 16'h2000, 1'b0, 16'h4000, 1'b0, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom);
      rb = (k == 5) ? 16'h0000 : 16'($urandom);
      run_op("rnd", ra, 1'($urandom), rb, 1'($urandom), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
